// File: rtl/mor1kx_spr_master_pkg.sv
// mor1kx_spr_master_pkg: SPR bus widths, address helpers and well-known SPR addresses
package mor1kx_spr_master_pkg;
  localparam int SPR_AW = 16;
  localparam int SPR_DW = 32;
  typedef logic [SPR_AW-1:0] spr_addr_t;
  typedef logic [SPR_DW-1:0] spr_dat_t;
  localparam spr_addr_t OR1K_SPR_PICMR_ADDR = 16'h4800;
  localparam spr_addr_t OR1K_SPR_PICSR_ADDR = 16'h4802;
  localparam spr_addr_t OR1K_SPR_TTMR_ADDR = 16'h5000;
  localparam spr_addr_t OR1K_SPR_TTCR_ADDR = 16'h5001;
  function automatic logic [4:0] spr_group(input spr_addr_t a);
    return a[15:11];
  endfunction
  function automatic logic [10:0] spr_offset(input spr_addr_t a);
    return a[10:0];
  endfunction
endpackage

// File: rtl/mor1kx_spr_master_timer.sv
// mor1kx_spr_master_timer: counts un-acked access cycles and flags expiry at the limit
module mor1kx_spr_master_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       cnt_en_i,
  input  logic [7:0] limit_i,
  output logic       expired_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = start_i ? 8'd0 : cnt_en_i ? cnt_q + 8'd1 : cnt_q;
  // expiry fires in the cycle whose missing ack brings the count to the limit
  assign expired_o = cnt_en_i && (cnt_q == limit_i - 8'd1);
  always_ff @(posedge clk)
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mor1kx_spr_master.sv
// mor1kx_spr_master: single-transaction SPR bus initiator; MOR1KX_SPR_TIMEOUT_EN adds a no-ack abort
module mor1kx_spr_master
  import mor1kx_spr_master_pkg::*;
#(
  parameter int OPTION_SPR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t    state_q, state_d;
  logic      we_q, we_d;
  spr_addr_t addr_q, addr_d;
  spr_dat_t  dat_q, dat_d;
  logic      rsp_valid_q, rsp_valid_d;
  spr_dat_t  rsp_dat_q, rsp_dat_d;
  logic      rsp_err_q, rsp_err_d;
  logic      accept, expired, done;
  assign accept = req_valid_i && (state_q == IDLE);
`ifdef MOR1KX_SPR_TIMEOUT_EN
  mor1kx_spr_master_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept),
    .cnt_en_i  ((state_q == ACCESS) && !spr_bus_ack_i),
    .limit_i   (8'(OPTION_SPR_TIMEOUT)),
    .expired_o (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(OPTION_SPR_TIMEOUT);
  assign expired = 1'b0;
`endif
  assign done = (state_q == ACCESS) && (spr_bus_ack_i || expired);
  always_comb begin
    state_d = accept ? ACCESS : done ? IDLE : state_q;
    we_d = accept ? req_we_i : we_q;
    addr_d = accept ? req_addr_i : addr_q;
    dat_d = accept ? req_dat_i : dat_q;
    rsp_valid_d = done;
    rsp_dat_d = done ? ((spr_bus_ack_i && !we_q) ? spr_dat_i : '0) : rsp_dat_q;
    rsp_err_d = done ? !spr_bus_ack_i : rsp_err_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      dat_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      dat_q <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  assign req_ready_o = (state_q == IDLE);
  assign busy_o = (state_q == ACCESS);
  assign spr_access_o = (state_q == ACCESS);
  assign spr_we_o = we_q && (state_q == ACCESS);
  assign spr_addr_o = addr_q;
  assign spr_dat_o = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;
endmodule

// File: tb/tb_mor1kx_spr_master.sv
// tb_mor1kx_spr_master: table-driven SPR master checks plus back-to-back, reset-abort and timeout sequences
module tb_mor1kx_spr_master;
  import mor1kx_spr_master_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        spr_access_o;
  logic        spr_we_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack_i;
  logic [31:0] spr_dat_i = '0;
  logic        ack_force = 1'b0;
  int          delay = 0;
  int          acc_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mor1kx_spr_master #(.OPTION_SPR_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_dat_i    (req_dat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .spr_access_o (spr_access_o),
    .spr_we_o     (spr_we_o),
    .spr_addr_o   (spr_addr_o),
    .spr_dat_o    (spr_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i),
    .spr_dat_i    (spr_dat_i)
  );

  always #5 clk = ~clk;

  // responder acks combinationally once the access has lasted delay+1 cycles
  always @(posedge clk) acc_cnt <= spr_access_o ? acc_cnt + 1 : 0;
  assign spr_bus_ack_i = ack_force || (spr_access_o && acc_cnt == delay);

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] dat;
    int          dly;
    logic [31:0] rd;
    int          exp_width;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int width;
    logic stable;
    delay = v.dly;
    spr_dat_i = v.rd;
    req_we_i = v.we;
    req_addr_i = v.addr;
    req_dat_i = v.dat;
    req_valid_i = 1'b1;
    chk("req_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    req_addr_i = ~v.addr;
    req_dat_i = ~v.dat;
    req_we_i = ~v.we;
    @(negedge clk);
    width = 0;
    stable = 1'b1;
    while (spr_access_o && width < 64) begin
      if (spr_addr_o !== v.addr || spr_dat_o !== v.dat || spr_we_o !== v.we || busy_o !== 1'b1) stable = 1'b0;
      width++;
      @(negedge clk);
    end
    chk("bus_stable", {31'd0, stable}, 32'd1);
    chk("access_width", width, v.exp_width);
    chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("rsp_dat", rsp_dat_o, v.exp_dat);
    chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, v.exp_err});
    chk("idle_we", {30'd0, spr_we_o, busy_o}, 32'd0);
    @(negedge clk);
    chk("rsp_pulse", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  vec_t vecs[5];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, OR1K_SPR_PICMR_ADDR, 32'h0000_0005, 0, 32'hDEAD_BEEF, 1, 32'h0, 1'b0};
    vecs[1] = '{1'b0, OR1K_SPR_PICSR_ADDR, 32'h0, 3, 32'hA5A5_0001, 4, 32'hA5A5_0001, 1'b0};
    vecs[2] = '{1'b0, OR1K_SPR_TTCR_ADDR, 32'h0, 0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 2, 32'h5555_AAAA, 3, 32'h0, 1'b0};
    vecs[4] = '{1'b0, OR1K_SPR_TTMR_ADDR, 32'h0, 1, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ctrl", {27'd0, req_ready_o, busy_o, spr_access_o, spr_we_o, rsp_valid_o}, 32'h10);
    chk("rst_addr", {16'd0, spr_addr_o}, 32'd0);
    chk("rst_dat", spr_dat_o, 32'd0);
    chk("rst_rsp", {rsp_dat_o[31:1], rsp_dat_o[0] | rsp_err_o}, 32'd0);
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
    // IDLE address/data hold the last transaction's values
    chk("idle_addr_hold", {16'd0, spr_addr_o}, {16'd0, OR1K_SPR_TTMR_ADDR});
    // ack while idle must not produce a response
    ack_force = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_ignored", {30'd0, rsp_valid_o, busy_o}, 32'd0);
    end
    ack_force = 1'b0;
    // three back-to-back requests with immediate ack
    delay = 0;
    spr_dat_i = 32'hCAFE_0003;
    req_we_i = 1'b0;
    req_addr_i = 16'h0010;
    req_valid_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_access_c%0d", c), {31'd0, spr_access_o}, {31'd0, c[0]});
      chk($sformatf("b2b_rsp_c%0d", c), {31'd0, rsp_valid_o}, {31'd0, ~c[0]});
      chk($sformatf("b2b_ready_c%0d", c), {31'd0, req_ready_o}, {31'd0, ~c[0]});
      if (c == 5) req_valid_i = 1'b0;
    end
    chk("b2b_dat", rsp_dat_o, 32'hCAFE_0003);
    @(negedge clk);
    chk("b2b_done", {30'd0, spr_access_o, rsp_valid_o}, 32'd0);
`ifndef MOR1KX_SPR_TIMEOUT_EN
    v = '{1'b0, 16'h0020, 32'h0, 19, 32'h7777_0020, 20, 32'h7777_0020, 1'b0};
    run_txn(v);
`else
    v = '{1'b0, 16'h0030, 32'h0, 1000, 32'h1111_2222, 4, 32'h0, 1'b1};
    run_txn(v);
    v = '{1'b0, 16'h0031, 32'h0, 3, 32'h3333_4444, 4, 32'h3333_4444, 1'b0};
    run_txn(v);
`endif
    // reset during a stalled access drops the transaction
    delay = 1000;
    req_we_i = 1'b0;
    req_addr_i = 16'h0040;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("stall_access1", {31'd0, spr_access_o}, 32'd1);
    @(negedge clk);
    chk("stall_access2", {31'd0, spr_access_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_abort_ctrl", {29'd0, spr_access_o, req_ready_o, rsp_valid_o}, 32'h2);
    @(negedge clk);
    chk("rst_abort_norsp", {30'd0, rsp_valid_o, spr_access_o}, 32'd0);
    @(negedge clk);
    chk("rst_abort_idle", {30'd0, rsp_valid_o, busy_o}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
